// File: rtl/div_arb_pkg.sv
// div_arbiter shared definitions
// FSM encoding, error codes and the divide-by-zero quotient.
package div_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    LAUNCH = ST_LAUNCH,
    WAIT   = ST_WAIT,
    RESP   = ST_RESP
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  // all-ones quotient, sliced to the operand width at the use site
  localparam logic [63:0] DIV0_QUO = '1;

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Combinational round-robin picker
// Search starts at ptr and wraps; first active request wins.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] id
);

  int   idx;
  logic found;

  // walk the requesters from ptr, wrapping at N
  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        id       = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider between N requesters
// Round-robin grant, divider launch, watchdog and response bus.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int W   = 32,
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int TMO = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_dvnd,
  input  logic [N*W-1:0] req_dvsr,
  output logic [N-1:0]   req_ready,
  output logic           rsp_valid,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   rsp_quo,
  output logic [W-1:0]   rsp_rmd,
  output logic [1:0]     rsp_err,
  output logic           busy,
  output logic           div_str_trg,
  output logic [W-1:0]   div_dvnd,
  output logic [W-1:0]   div_dvsr,
  input  logic           div_ready,
  input  logic           div_done_trg,
  input  logic [W-1:0]   div_quo,
  input  logic [W-1:0]   div_rmd
);

  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_C = CW'(TMO);

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_q;
  logic [CW-1:0]  wdog;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gid;
  logic [W-1:0]   sel_dvnd;
  logic [W-1:0]   sel_dvsr;
  logic           accept;
  logic           sel_zero;
  logic           tmo_hit;

  rr_arbiter #(.N(N), .IDW(IDW)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .id  (gid)
  );

  assign sel_dvnd = req_dvnd[gid*W +: W];
  assign sel_dvsr = req_dvsr[gid*W +: W];
  assign sel_zero = (sel_dvsr == '0);
  assign accept   = (state == IDLE) && div_ready && (|req_valid);
  assign tmo_hit  = (wdog == TMO_C);

  // reset gating keeps the accept pulse quiet while reset is held
  assign req_ready   = (accept && !reset) ? gnt : '0;
  assign div_str_trg = (state == LAUNCH);
  assign rsp_valid   = (state == RESP);
  assign busy        = (state != IDLE);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state: zero divisor skips the divider entirely
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = sel_zero ? RESP : LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT:    if (div_done_trg || tmo_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // operand latch, pointer, watchdog and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_dvnd <= '0;
      div_dvsr <= '0;
      id_q     <= '0;
      rr_ptr   <= '0;
      wdog     <= '0;
      rsp_id   <= '0;
      rsp_quo  <= '0;
      rsp_rmd  <= '0;
      rsp_err  <= ERR_OK;
    end else begin
      if (accept) begin
        div_dvnd <= sel_dvnd;
        div_dvsr <= sel_dvsr;
        id_q     <= gid;
        rr_ptr   <= (gid == IDW'(N - 1)) ? '0 : gid + 1'b1;
        if (sel_zero) begin
          rsp_id  <= gid;
          rsp_quo <= DIV0_QUO[W-1:0];
          rsp_rmd <= sel_dvnd;
          rsp_err <= ERR_DIV0;
        end
      end
      if (state == WAIT) begin
        if (div_done_trg) begin
          rsp_id  <= id_q;
          rsp_quo <= div_quo;
          rsp_rmd <= div_rmd;
          rsp_err <= ERR_OK;
        end else if (tmo_hit) begin
          rsp_id  <= id_q;
          rsp_quo <= '0;
          rsp_rmd <= '0;
          rsp_err <= ERR_TMO;
        end
      end
      wdog <= (state == WAIT) ? wdog + 1'b1 : '0;
    end
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Shares one sequential divider (`div`, quotient/remainder by shift-subtract) between N requesters. Requesters present dividend/divisor with a valid/ready handshake. The block grants round-robin, launches the divider, and waits for its done pulse. It then returns quotient, remainder, requester ID and status on a shared response bus. It sits between the software-visible accelerator ports and the single `div` instance, and drives that instance's `str_trg`/`dvnd`/`dvsr` directly.

## Interface
- W, 32, operand width; must match the divider's W
- N, 4, number of requesters (2..16)
- IDW, 2, requester ID width, ceil(log2 N)
- TMO, 64, watchdog limit in WAIT cycles; must be > W+4
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; also wired to the divider
- req_valid  in  N  per-requester request
- req_dvnd  in  N*W  packed dividends, requester i at [i*W +: W]
- req_dvsr  in  N*W  packed divisors
- req_ready  out  N  one-hot one-cycle accept pulse
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  IDW  index of the requester being answered
- rsp_quo  out  W  quotient
- rsp_rmd  out  W  remainder
- rsp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout
- busy  out  1  high in every state except IDLE
- div_str_trg  out  1  divider start, one-cycle pulse
- div_dvnd, div_dvsr  out  W each  registered operands to the divider
- div_ready  in  1  divider idle
- div_done_trg  in  1  divider completion pulse
- div_quo, div_rmd  in  W each  divider results

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- **IDLE.** If any req_valid is set and div_ready=1, the round-robin arbiter picks a winner i, starting the search at rr_ptr.
  - req_ready[i] pulses; operands and i are latched.
  - rr_ptr becomes (i+1) mod N.
- **Divide-by-zero.** If the latched dvsr is 0, the divider is bypassed.
  - Result is quo = all ones, rmd = dvnd, err = 01.
  - Next state is RESP.
  - Otherwise next state is LAUNCH.
- **LAUNCH.** div_str_trg = 1 for exactly one cycle; div_dvnd/div_dvsr hold the latched operands; go to WAIT.
- **WAIT.** The watchdog counter increments every cycle.
  - On div_done_trg: capture div_quo/div_rmd, set err = 00, go to RESP.
  - If the counter reaches TMO first: quo = rmd = 0, err = 10, go to RESP.
- **RESP.** rsp_valid = 1 with rsp_id/quo/rmd/err for one cycle; go to IDLE.
- **Request protocol.** A requester holds req_valid and its operands stable until it sees req_ready.
  - If req_valid drops before a grant, that requester is simply skipped.
  - Only one operation is ever outstanding.
- **Late or spurious completion.** div_done_trg outside WAIT is ignored. A late done after a timeout is therefore discarded.
- **Response bus.** rsp_quo/rmd/err/id hold their last values between pulses; only rsp_valid qualifies them.

## Timing
- Reset: all outputs 0, state IDLE, rr_ptr 0, watchdog 0, result registers 0. Reset mid-operation aborts with no response pulse.
- **Normal divide.** Let T be the accept cycle.
  - T: req_ready.
  - T+1: div_str_trg.
  - The divider's done arrives at cycle D.
  - D+1: rsp_valid.
  - D+2: the next accept is possible.
- **Divide-by-zero.** Accept at T, rsp_valid at T+1, next accept at T+2.
- **Timeout.** rsp_valid arrives TMO+1 cycles after entering WAIT.
- **No grant.** No grant happens while div_ready=0 in IDLE.
- **Fairness.** With all N requesting continuously, grants rotate 0,1,…,N-1,0.

## Structure
- Package `div_arb_pkg` holds:
  - FSM state localparams (2-bit encoding)
  - error code constants ERR_OK/ERR_DIV0/ERR_TMO
  - the DIV0 quotient constant
- Sub-module `rr_arbiter` (N, IDW): inputs req[N], ptr; outputs one-hot gnt and encoded id. It is purely combinational; rr_ptr lives in div_arbiter.
- The `div` instance is external and is connected by the integrating top level.

## Test plan
- **Single request.** Requester 2 requests 100/7 → req_ready[2] at T, div_str_trg at T+1, then rsp_valid with id 2, quo 14, rmd 2, err 00.
- **Divide-by-zero.** Requester 0 requests 55/0 → rsp_valid at T+1 with quo 0xFFFFFFFF, rmd 55, err 01; div_str_trg never asserts.
- **Fairness.** All four request continuously (operand pair i*10+9 / 3) → grant order 0,1,2,3,0; every response carries the correct id and quotient.
- **Timeout.** Stub divider never pulses done → rsp_valid TMO+1 cycles after WAIT entry with err 10 and quo/rmd 0; a late done afterwards causes no extra rsp_valid.
- **Reset abort.** Reset asserted during WAIT → all outputs 0 immediately; after release, requester 1 issues 9/3 → quo 3, rmd 0, and is granted first because rr_ptr restarts at 0.
- **Divider not ready.** div_ready held 0 with req_valid[3]=1 → no req_ready. When div_ready rises, req_ready[3] pulses on that cycle.
